dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: target end of the CPU core's D_MEM_* request interface.
//  Single-port word-addressed SRAM model with byte-enable writes and a READ_LAT-deep read pipeline.
//  Sits outside the core in the testbench/SoC top; feeds read data back to the core on D_MEM_DI.
//  Accepts one request per cycle with no back-pressure; keeps access counters for bring-up checks.
// PARAMETERS
//  DEPTH_LOG2  10  storage = 2**DEPTH_LOG2 32-bit words (legal 4..12)
//  READ_LAT    1   cycles from read accept to RD_VALID (legal 1..4)
// PORTS
//  CLK         in   1   single clock, all state updates on rising edge
//  RST         in   1   synchronous reset, active-high
//  D_MEM_CSN   in   1   chip select, active-low; request present when 0
//  D_MEM_WEN   in   1   0 = write, 1 = read (sampled only when D_MEM_CSN=0)
//  D_MEM_BE    in   4   byte enables for writes; bit i -> data[8i+7:8i]
//  D_MEM_ADDR  in   12  word address
//  D_MEM_DOUT  in   32  write data from core
//  D_MEM_DI    out  32  read data to core
//  RD_VALID    out  1   D_MEM_DI carries a completed read this cycle
//  RD_ERR      out  1   completed read was out of range (qualified by RD_VALID)
//  WR_ERR      out  1   pulse: write in previous cycle was out of range, dropped
//  RD_CNT      out  32  accepted reads since reset, wraps at 2**32
//  WR_CNT      out  32  accepted writes since reset, wraps at 2**32
// BEHAVIOUR
//  Reset: D_MEM_DI=0, RD_VALID=0, RD_ERR=0, WR_ERR=0, RD_CNT=0, WR_CNT=0; read pipeline flushed.
//   Storage contents are NOT cleared by RST.
//  Idle: CSN=1 -> no state change except pipeline advance; counters hold.
//  In range: ADDR < 2**DEPTH_LOG2. Out of range never aliases or wraps.
//  Write (CSN=0, WEN=0) accepted at edge t:
//   - in range: for each BE[i]=1, mem[ADDR] byte i <= DOUT byte i; BE=4'b0000 changes nothing.
//   - out of range: storage untouched; WR_ERR=1 for the cycle after t.
//   - WR_CNT += 1 in both cases, including BE=0.
//  Read (CSN=0, WEN=1) accepted at edge t:
//   - array sampled at edge t; read data = mem[ADDR] (0 if out of range).
//   - after edge t+READ_LAT-1: RD_VALID=1, D_MEM_DI=data, RD_ERR=out-of-range flag.
//     READ_LAT=1 -> valid in the cycle immediately after accept.
//   - RD_CNT += 1.
//  Pipeline: READ_LAT stages of {valid, err, data}, shifting every cycle, no stall.
//   Back-to-back reads each complete in order, one per cycle.
//  Ordering / hazards:
//   - Write at t then read of same word at t+1 returns the new data.
//   - A write landing while a read is in flight does not alter that read's data.
//  D_MEM_DI holds its last value while RD_VALID=0. RD_ERR is 0 whenever RD_VALID=0.
//  RST asserted mid-operation: in-flight reads dropped, no RD_VALID for them.
//   A request presented in a reset cycle is ignored.
//  Counters wrap from 32'hFFFF_FFFF to 0 without error.
// TESTING
//  Write ADDR=5, DOUT=32'hDEADBEEF, BE=4'hF; read ADDR=5 next cycle
//   -> RD_VALID after READ_LAT cycles, D_MEM_DI=32'hDEADBEEF, RD_ERR=0.
//  Partial write on word holding 32'hDEADBEEF: ADDR=5, DOUT=32'h000000AA, BE=4'b0001
//   -> read returns 32'hDEADBEAA; repeat with BE=0 -> word and read data unchanged, WR_CNT still +1.
//  DEPTH_LOG2=10: write ADDR=12'h400 -> WR_ERR pulse, mem[0] unchanged;
//   read ADDR=12'h400 -> RD_VALID=1, RD_ERR=1, D_MEM_DI=0.
//  READ_LAT=3: 4 consecutive reads of ADDR 0..3 holding 1,2,3,4
//   -> RD_VALID high 4 cycles starting 3 cycles after first accept, data 1,2,3,4 in order.
//  READ_LAT=3: read ADDR=7 in flight, RST for 1 cycle
//   -> no RD_VALID for that read, RD_CNT=0, WR_CNT=0; mem[7] retained on re-read.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bundle between the CPU core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        csn;
    logic        wen;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] dout;
    logic [31:0] di;
    logic        rd_valid;
    logic        rd_err;

    modport master (
        output csn, wen, be, addr, dout,
        input  di, rd_valid, rd_err
    );

    modport slave (
        input  csn, wen, be, addr, dout,
        output di, rd_valid, rd_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed SRAM model with byte-enable writes, a fixed-latency read pipeline
// and access counters; answers the core's data-memory requests without back-pressure.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic        wr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_r [DEPTH];
    logic                  pipe_valid_r [READ_LAT];
    logic                  pipe_err_r   [READ_LAT];
    logic [31:0]           pipe_data_r  [READ_LAT];
    logic                  wr_err_r;
    logic [31:0]           rd_cnt_r;
    logic [31:0]           wr_cnt_r;

    logic                  req_rd_s;
    logic                  req_wr_s;
    logic                  in_range_s;
    logic                  in_err_s;
    logic [11:0]           addr_hi_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [31:0]           rd_word_s;

    // Decode the request; anything presented while in reset is ignored.
    always_comb begin
        req_rd_s   = 1'b0;
        req_wr_s   = 1'b0;
        addr_hi_s  = bus.addr >> DEPTH_LOG2;
        in_range_s = (addr_hi_s == 12'd0);
        idx_s      = bus.addr[DEPTH_LOG2-1:0];
        if (!rst && !bus.csn) begin
            if (bus.wen) begin
                req_rd_s = 1'b1;
            end else begin
                req_wr_s = 1'b1;
            end
        end else begin
            req_rd_s = 1'b0;
            req_wr_s = 1'b0;
        end
    end

    // Sample the array for an accepted read; out-of-range returns zero and never aliases.
    always_comb begin
        rd_word_s = 32'd0;
        in_err_s  = 1'b0;
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s];
            in_err_s  = 1'b0;
        end else begin
            rd_word_s = 32'd0;
            in_err_s  = req_rd_s;
        end
    end

    // Storage update: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (req_wr_s && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    mem_r[idx_s][8*i +: 8] <= bus.dout[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline; data only moves with a valid token so the last stage holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_valid_r[i] <= 1'b0;
                pipe_err_r[i]   <= 1'b0;
                pipe_data_r[i]  <= 32'd0;
            end
        end else begin
            pipe_valid_r[0] <= req_rd_s;
            pipe_err_r[0]   <= in_err_s;
            if (req_rd_s) begin
                pipe_data_r[0] <= rd_word_s;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                if (pipe_valid_r[i-1]) begin
                    pipe_data_r[i] <= pipe_data_r[i-1];
                end
            end
        end
    end

    // Access counters and the one-cycle dropped-write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r <= 1'b0;
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
        end else begin
            wr_err_r <= req_wr_s & ~in_range_s;
            if (req_rd_s) begin
                rd_cnt_r <= rd_cnt_r + 32'd1;
            end
            if (req_wr_s) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end
        end
    end

    assign bus.di       = pipe_data_r[READ_LAT-1];
    assign bus.rd_valid = pipe_valid_r[READ_LAT-1];
    assign bus.rd_err   = pipe_err_r[READ_LAT-1];
    assign wr_err       = wr_err_r;
    assign rd_cnt       = rd_cnt_r;
    assign wr_cnt       = wr_cnt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with READ_LAT=1 and one with READ_LAT=3, both DEPTH_LOG2=10.
module tb_dmem_responder;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic        wr_err_a;
    logic        wr_err_b;
    logic [31:0] rd_cnt_a;
    logic [31:0] wr_cnt_a;
    logic [31:0] rd_cnt_b;
    logic [31:0] wr_cnt_b;
    int          pass_cnt;
    int          total_cnt;

    dmem_if bus_a ();
    dmem_if bus_b ();

    dmem_responder #(.DEPTH_LOG2(10), .READ_LAT(1)) dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .bus    (bus_a),
        .wr_err (wr_err_a),
        .rd_cnt (rd_cnt_a),
        .wr_cnt (wr_cnt_a)
    );

    dmem_responder #(.DEPTH_LOG2(10), .READ_LAT(3)) dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .bus    (bus_b),
        .wr_err (wr_err_b),
        .rd_cnt (rd_cnt_b),
        .wr_cnt (wr_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic csn, input logic wen, input logic [3:0] be,
                           input logic [11:0] addr, input logic [31:0] dout);
        bus_a.csn = csn; bus_a.wen = wen; bus_a.be = be; bus_a.addr = addr; bus_a.dout = dout;
    endtask

    task automatic drive_b(input logic csn, input logic wen, input logic [3:0] be,
                           input logic [11:0] addr, input logic [31:0] dout);
        bus_b.csn = csn; bus_b.wen = wen; bus_b.be = be; bus_b.addr = addr; bus_b.dout = dout;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        tick(); tick();
        total_cnt++; if (bus_a.di !== 32'h0) $display("FAIL reset_di_a: got %h want 0", bus_a.di); else pass_cnt++;
        total_cnt++; if (bus_a.rd_valid !== 1'b0 || bus_a.rd_err !== 1'b0 || wr_err_a !== 1'b0)
            $display("FAIL reset_flags_a: got v=%b re=%b we=%b want 0", bus_a.rd_valid, bus_a.rd_err, wr_err_a); else pass_cnt++;
        total_cnt++; if (rd_cnt_a !== 32'h0 || wr_cnt_a !== 32'h0)
            $display("FAIL reset_cnt_a: got rd=%0d wr=%0d want 0", rd_cnt_a, wr_cnt_a); else pass_cnt++;
        total_cnt++; if (bus_b.di !== 32'h0 || bus_b.rd_valid !== 1'b0 || rd_cnt_b !== 32'h0 || wr_cnt_b !== 32'h0)
            $display("FAIL reset_b: got di=%h v=%b rd=%0d wr=%0d want 0", bus_b.di, bus_b.rd_valid, rd_cnt_b, wr_cnt_b); else pass_cnt++;
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_full_word();
        drive_a(1'b0, 1'b0, 4'hF, 12'h005, 32'hDEADBEEF); tick();
        drive_a(1'b0, 1'b1, 4'h0, 12'h005, 32'h0); tick();
        total_cnt++; if (bus_a.rd_valid !== 1'b1) $display("FAIL full_valid: got %b want 1", bus_a.rd_valid); else pass_cnt++;
        total_cnt++; if (bus_a.di !== 32'hDEADBEEF) $display("FAIL full_data: got %h want deadbeef", bus_a.di); else pass_cnt++;
        total_cnt++; if (bus_a.rd_err !== 1'b0) $display("FAIL full_err: got %b want 0", bus_a.rd_err); else pass_cnt++;
        drive_a(1'b1, 1'b1, 4'h0, 12'h000, 32'h0); tick();
        total_cnt++; if (bus_a.rd_valid !== 1'b0 || bus_a.rd_err !== 1'b0)
            $display("FAIL idle_flags: got v=%b e=%b want 0", bus_a.rd_valid, bus_a.rd_err); else pass_cnt++;
        total_cnt++; if (bus_a.di !== 32'hDEADBEEF) $display("FAIL idle_hold: got %h want deadbeef", bus_a.di); else pass_cnt++;
    endtask

    task automatic test_partial_write();
        drive_a(1'b0, 1'b0, 4'b0001, 12'h005, 32'h000000AA); tick();
        drive_a(1'b0, 1'b1, 4'h0, 12'h005, 32'h0); tick();
        total_cnt++; if (bus_a.di !== 32'hDEADBEAA) $display("FAIL be0001: got %h want deadbeaa", bus_a.di); else pass_cnt++;
        drive_a(1'b0, 1'b0, 4'b0000, 12'h005, 32'h12345678); tick();
        drive_a(1'b0, 1'b1, 4'h0, 12'h005, 32'h0); tick();
        total_cnt++; if (bus_a.di !== 32'hDEADBEAA) $display("FAIL be0000: got %h want deadbeaa", bus_a.di); else pass_cnt++;
        total_cnt++; if (wr_cnt_a !== 32'd3 || rd_cnt_a !== 32'd3)
            $display("FAIL be0_counts: got wr=%0d rd=%0d want 3 3", wr_cnt_a, rd_cnt_a); else pass_cnt++;
        drive_a(1'b0, 1'b0, 4'b1010, 12'h005, 32'h11223344); tick();
        drive_a(1'b0, 1'b1, 4'h0, 12'h005, 32'h0); tick();
        total_cnt++; if (bus_a.di !== 32'h11AD33AA) $display("FAIL be1010: got %h want 11ad33aa", bus_a.di); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        drive_a(1'b0, 1'b0, 4'hF, 12'h000, 32'h0BADF00D); tick();
        drive_a(1'b0, 1'b0, 4'hF, 12'h400, 32'hFFFFFFFF); tick();
        total_cnt++; if (wr_err_a !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", wr_err_a); else pass_cnt++;
        drive_a(1'b0, 1'b1, 4'h0, 12'h400, 32'h0); tick();
        total_cnt++; if (wr_err_a !== 1'b0) $display("FAIL oor_wr_err_pulse: got %b want 0", wr_err_a); else pass_cnt++;
        total_cnt++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_err !== 1'b1 || bus_a.di !== 32'h0)
            $display("FAIL oor_read: got v=%b e=%b d=%h want 1 1 0", bus_a.rd_valid, bus_a.rd_err, bus_a.di); else pass_cnt++;
        drive_a(1'b0, 1'b1, 4'h0, 12'h000, 32'h0); tick();
        total_cnt++; if (bus_a.di !== 32'h0BADF00D || bus_a.rd_err !== 1'b0)
            $display("FAIL oor_no_alias: got d=%h e=%b want 0badf00d 0", bus_a.di, bus_a.rd_err); else pass_cnt++;
        drive_a(1'b0, 1'b0, 4'hF, 12'h3FF, 32'h00000055); tick();
        total_cnt++; if (wr_err_a !== 1'b0) $display("FAIL top_wr_err: got %b want 0", wr_err_a); else pass_cnt++;
        drive_a(1'b0, 1'b1, 4'h0, 12'h3FF, 32'h0); tick();
        total_cnt++; if (bus_a.di !== 32'h00000055 || bus_a.rd_err !== 1'b0)
            $display("FAIL top_read: got d=%h e=%b want 00000055 0", bus_a.di, bus_a.rd_err); else pass_cnt++;
        drive_a(1'b0, 1'b1, 4'h0, 12'hFFF, 32'h0); tick();
        total_cnt++; if (bus_a.rd_err !== 1'b1 || bus_a.di !== 32'h0)
            $display("FAIL fff_read: got e=%b d=%h want 1 0", bus_a.rd_err, bus_a.di); else pass_cnt++;
        drive_a(1'b1, 1'b1, 4'h0, 12'h000, 32'h0); tick();
        total_cnt++; if (wr_cnt_a !== 32'd7 || rd_cnt_a !== 32'd8)
            $display("FAIL oor_counts: got wr=%0d rd=%0d want 7 8", wr_cnt_a, rd_cnt_a); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_d;
        for (int k = 0; k < 4; k++) begin
            drive_b(1'b0, 1'b0, 4'hF, 12'(k), 32'(k + 1)); tick();
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) drive_b(1'b0, 1'b1, 4'h0, 12'(k), 32'h0);
            else       drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
            tick();
            exp_v = (k >= 2 && k <= 5);
            exp_d = (k < 2) ? 32'd0 : ((k <= 5) ? 32'(k - 1) : 32'd4);
            total_cnt++; if (bus_b.rd_valid !== exp_v)
                $display("FAIL b2b_valid[%0d]: got %b want %b", k, bus_b.rd_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus_b.di !== exp_d || bus_b.rd_err !== 1'b0)
                $display("FAIL b2b_data[%0d]: got d=%h e=%b want %h 0", k, bus_b.di, bus_b.rd_err, exp_d); else pass_cnt++;
        end
    endtask

    task automatic test_inflight_write();
        drive_b(1'b0, 1'b0, 4'hF, 12'h007, 32'hA5A5A5A5); tick();
        drive_b(1'b0, 1'b1, 4'h0, 12'h007, 32'h0); tick();
        drive_b(1'b0, 1'b0, 4'hF, 12'h007, 32'h5A5A5A5A); tick();
        drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0); tick();
        total_cnt++; if (bus_b.rd_valid !== 1'b1 || bus_b.di !== 32'hA5A5A5A5)
            $display("FAIL inflight_old: got v=%b d=%h want 1 a5a5a5a5", bus_b.rd_valid, bus_b.di); else pass_cnt++;
        drive_b(1'b0, 1'b1, 4'h0, 12'h007, 32'h0); tick();
        drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0); tick(); tick();
        total_cnt++; if (bus_b.rd_valid !== 1'b1 || bus_b.di !== 32'h5A5A5A5A)
            $display("FAIL inflight_new: got v=%b d=%h want 1 5a5a5a5a", bus_b.rd_valid, bus_b.di); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        drive_b(1'b0, 1'b1, 4'h0, 12'h007, 32'h0); tick();
        rst_b = 1'b1;
        drive_b(1'b0, 1'b0, 4'hF, 12'h007, 32'h00000000); tick();
        total_cnt++; if (rd_cnt_b !== 32'd0 || wr_cnt_b !== 32'd0 || bus_b.di !== 32'h0)
            $display("FAIL midrst_state: got rd=%0d wr=%0d d=%h want 0 0 0", rd_cnt_b, wr_cnt_b, bus_b.di); else pass_cnt++;
        rst_b = 1'b0;
        drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++; if (bus_b.rd_valid !== 1'b0)
                $display("FAIL midrst_dropped[%0d]: got %b want 0", k, bus_b.rd_valid); else pass_cnt++;
        end
        drive_b(1'b0, 1'b1, 4'h0, 12'h007, 32'h0); tick();
        drive_b(1'b1, 1'b1, 4'h0, 12'h000, 32'h0); tick(); tick();
        total_cnt++; if (bus_b.rd_valid !== 1'b1 || bus_b.di !== 32'h5A5A5A5A)
            $display("FAIL midrst_retained: got v=%b d=%h want 1 5a5a5a5a", bus_b.rd_valid, bus_b.di); else pass_cnt++;
        total_cnt++; if (rd_cnt_b !== 32'd1 || wr_cnt_b !== 32'd0)
            $display("FAIL midrst_counts: got rd=%0d wr=%0d want 1 0", rd_cnt_b, wr_cnt_b); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        test_reset();
        test_full_word();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_inflight_write();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
